// File: rtl/alarm_control_module.sv
// Alarm compare and ring/snooze/stop FSM driven by the packed current-time word.
// Optional beeping buzzer when ALARM_BEEP_EN is defined; otherwise the buzzer is a steady level.
module alarm_control_module #(
    parameter int SNOOZE_MIN   = 5,
    parameter int MAX_SNOOZE   = 3,
    parameter int RING_TIMEOUT = 10,
    parameter int BEEP_BITS    = 4
) (
    input  logic        Clk,
    input  logic        Clr_AC,
    input  logic [14:0] CTI,
    input  logic [11:0] ATI,
    input  logic [6:0]  DAY_MASK,
    input  logic        EN_AL,
    input  logic        Snooze,
    input  logic        Stop,
    output logic        Buzz,
    output logic        Alarm_Active,
    output logic        Snoozing,
    output logic [1:0]  AL_State
);
    localparam logic [3:0] SNZ_MIN = SNOOZE_MIN[3:0];
    localparam logic [3:0] MAX_SNZ = MAX_SNOOZE[3:0];
    localparam logic [3:0] RING_TO = RING_TIMEOUT[3:0];

    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 15 || MAX_SNOOZE < 0 || MAX_SNOOZE > 7 ||
        RING_TIMEOUT < 1 || RING_TIMEOUT > 15 || BEEP_BITS < 1) begin : g_bad_param
        $error("alarm_control_module: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] ring_cnt, ring_cnt_nxt;
    logic [3:0] snz_cnt, snz_cnt_nxt;
    logic [3:0] snz_used, snz_used_nxt;
    logic [3:0] prev_min;
    logic [7:0] day_en;
    logic       tick, match, at_alarm;

    // Day code 7 lands on the padding bit, so it can never arm the alarm.
    assign day_en   = {1'b0, DAY_MASK};
    assign at_alarm = (CTI[11:0] == ATI);
    assign match    = EN_AL & at_alarm & day_en[CTI[14:12]];
    assign tick     = (CTI[3:0] != prev_min);

    always_ff @(posedge Clk or posedge Clr_AC) begin
        if (Clr_AC) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_used <= '0;
            prev_min <= '0;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_cnt_nxt;
            snz_cnt  <= snz_cnt_nxt;
            snz_used <= snz_used_nxt;
            prev_min <= CTI[3:0];
        end
    end

    always_comb begin
        state_nxt    = state;
        ring_cnt_nxt = ring_cnt;
        snz_cnt_nxt  = snz_cnt;
        snz_used_nxt = snz_used;
        if (!EN_AL) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (match) begin
                    state_nxt    = RINGING;
                    ring_cnt_nxt = '0;
                    snz_used_nxt = '0;
                end
                RINGING: begin
                    if (Stop) begin
                        state_nxt = DONE;
                    end else if (Snooze && (snz_used < MAX_SNZ)) begin
                        state_nxt    = SNOOZE;
                        snz_cnt_nxt  = SNZ_MIN;
                        snz_used_nxt = (snz_used == 4'hF) ? snz_used : snz_used + 4'd1;
                    end else if (tick) begin
                        ring_cnt_nxt = (ring_cnt == 4'hF) ? ring_cnt : ring_cnt + 4'd1;
                        if (ring_cnt_nxt >= RING_TO) state_nxt = DONE;
                    end
                end
                SNOOZE: begin
                    if (Stop) begin
                        state_nxt = DONE;
                    end else if (tick) begin
                        snz_cnt_nxt = (snz_cnt == 4'd0) ? snz_cnt : snz_cnt - 4'd1;
                        if (snz_cnt <= 4'd1) begin
                            state_nxt    = RINGING;
                            ring_cnt_nxt = '0;
                        end
                    end
                end
                DONE: if (!at_alarm) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign AL_State     = state;
    assign Alarm_Active = (state == RINGING) || (state == SNOOZE);
    assign Snoozing     = (state == SNOOZE);

`ifdef ALARM_BEEP_EN
    logic [BEEP_BITS-1:0] beep_cnt;

    // Held at zero outside RINGING, so every entry starts with the high half of a beep.
    always_ff @(posedge Clk or posedge Clr_AC) begin
        if (Clr_AC)                 beep_cnt <= '0;
        else if (state != RINGING)  beep_cnt <= '0;
        else                        beep_cnt <= beep_cnt + 1'b1;
    end

    assign Buzz = (state == RINGING) & ~beep_cnt[BEEP_BITS-1];
`else
    assign Buzz = (state == RINGING);
`endif
endmodule

// File: tb/tb_alarm_control_module.sv
// Bench for alarm_control_module: directed vector table, hand sequences for
// snooze/timeout/reset corners, then random stimulus against a behavioural model.
module tb_alarm_control_module;
    localparam int SNOOZE_MIN   = 5;
    localparam int MAX_SNOOZE   = 3;
    localparam int RING_TIMEOUT = 10;
    localparam int BEEP_BITS    = 4;

    logic        Clk = 1'b0;
    logic        Clr_AC = 1'b1;
    logic [14:0] CTI = '0;
    logic [11:0] ATI = '0;
    logic [6:0]  DAY_MASK = '0;
    logic        EN_AL = 1'b0, Snooze = 1'b0, Stop = 1'b0;
    logic        Buzz, Alarm_Active, Snoozing;
    logic [1:0]  AL_State;

    int total = 0;
    int bad   = 0;

    alarm_control_module #(
        .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE),
        .RING_TIMEOUT(RING_TIMEOUT), .BEEP_BITS(BEEP_BITS)
    ) dut (
        .Clk(Clk), .Clr_AC(Clr_AC), .CTI(CTI), .ATI(ATI), .DAY_MASK(DAY_MASK),
        .EN_AL(EN_AL), .Snooze(Snooze), .Stop(Stop), .Buzz(Buzz),
        .Alarm_Active(Alarm_Active), .Snoozing(Snoozing), .AL_State(AL_State)
    );

    always #5 Clk = ~Clk;

    function automatic logic [14:0] tm(int d, int h, int m);
        logic [2:0] dd = d[2:0];
        logic [4:0] hh = h[4:0];
        logic [2:0] mt = 3'(m / 10);
        logic [3:0] mo = 4'(m % 10);
        return {dd, hh, mt, mo};
    endfunction

    // Behavioural model: mode 0 idle, 1 ringing, 2 snoozing, 3 done
    int m_mode, m_rung, m_left, m_taken, m_last, m_beep;

    task automatic model_reset();
        m_mode = 0; m_rung = 0; m_left = 0; m_taken = 0; m_last = 0; m_beep = 0;
    endtask

    task automatic model_step();
        int  day  = int'(CTI[14:12]);
        bit  tick = (int'(CTI[3:0]) != m_last);
        bit  same = (CTI[11:0] == ATI);
        bit  hit  = EN_AL && same && (day != 7) && DAY_MASK[day[2:0]];
        int  old  = m_mode;
        if (!EN_AL) m_mode = 0;
        else if (m_mode == 0) begin
            if (hit) begin m_mode = 1; m_rung = 0; m_taken = 0; end
        end else if (m_mode == 1) begin
            if (Stop) m_mode = 3;
            else if (Snooze && m_taken < MAX_SNOOZE) begin
                m_mode = 2; m_left = SNOOZE_MIN; m_taken++;
            end else if (tick) begin
                m_rung++;
                if (m_rung >= RING_TIMEOUT) m_mode = 3;
            end
        end else if (m_mode == 2) begin
            if (Stop) m_mode = 3;
            else if (tick) begin
                m_left--;
                if (m_left <= 0) begin m_mode = 1; m_rung = 0; end
            end
        end else if (!same) m_mode = 0;
        m_beep = (old == 1 && m_mode == 1) ? m_beep + 1 : 0;
        m_last = int'(CTI[3:0]);
    endtask

    function automatic bit model_buzz();
`ifdef ALARM_BEEP_EN
        return (m_mode == 1) && ((m_beep % (1 << BEEP_BITS)) < (1 << (BEEP_BITS - 1)));
`else
        return (m_mode == 1);
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge Clk); #1;
        chk("model_state", 32'(AL_State), 32'(m_mode));
        chk("model_buzz", 32'(Buzz), 32'(model_buzz()));
        chk("model_active", 32'(Alarm_Active), 32'(m_mode == 1 || m_mode == 2));
        chk("model_snoozing", 32'(Snoozing), 32'(m_mode == 2));
    endtask

    task automatic drive(logic [14:0] c, logic [6:0] mk, logic en, logic sz, logic sp);
        CTI = c; DAY_MASK = mk; EN_AL = en; Snooze = sz; Stop = sp;
    endtask

    typedef struct {
        logic [14:0] cti;
        logic [6:0]  mask;
        logic        en, snz, stp;
        logic [1:0]  exp;
    } vec_t;

    function automatic vec_t mkv(logic [14:0] c, logic [6:0] mk, logic en,
                                 logic sz, logic sp, logic [1:0] e);
        vec_t v;
        v.cti = c; v.mask = mk; v.en = en; v.snz = sz; v.stp = sp; v.exp = e;
        return v;
    endfunction

    vec_t vecs[14];
    int   ones;

    initial begin
        ATI = 12'(tm(0, 7, 30));
        vecs[0]  = mkv(tm(1, 7, 29), 7'b0000010, 1, 0, 0, 2'b00);
        vecs[1]  = mkv(tm(1, 7, 30), 7'b0000010, 1, 0, 0, 2'b01);
        vecs[2]  = mkv(tm(1, 7, 30), 7'b0000010, 1, 1, 0, 2'b10);
        vecs[3]  = mkv(tm(1, 7, 31), 7'b0000010, 1, 0, 0, 2'b10);
        vecs[4]  = mkv(tm(1, 7, 32), 7'b0000010, 1, 0, 0, 2'b10);
        vecs[5]  = mkv(tm(1, 7, 33), 7'b0000010, 1, 1, 0, 2'b10);
        vecs[6]  = mkv(tm(1, 7, 34), 7'b0000010, 1, 0, 0, 2'b10);
        vecs[7]  = mkv(tm(1, 7, 35), 7'b0000010, 1, 0, 0, 2'b01);
        vecs[8]  = mkv(tm(1, 7, 35), 7'b0000010, 1, 1, 1, 2'b11);
        vecs[9]  = mkv(tm(1, 7, 36), 7'b0000010, 1, 0, 0, 2'b00);
        vecs[10] = mkv(tm(2, 7, 30), 7'b0000010, 1, 0, 0, 2'b00);
        vecs[11] = mkv(tm(7, 7, 30), 7'b1111111, 1, 0, 0, 2'b00);
        vecs[12] = mkv(tm(1, 7, 30), 7'b0000010, 1, 0, 0, 2'b01);
        vecs[13] = mkv(tm(1, 7, 30), 7'b0000010, 0, 0, 0, 2'b00);

        // Reset state
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_state", 32'(AL_State), 0);
        chk("reset_buzz", 32'(Buzz), 0);
        chk("reset_active", 32'(Alarm_Active), 0);
        chk("reset_snoozing", 32'(Snoozing), 0);
        Clr_AC = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].cti, vecs[i].mask, vecs[i].en, vecs[i].snz, vecs[i].stp);
            cyc();
            chk($sformatf("vec%0d_state", i), 32'(AL_State), 32'(vecs[i].exp));
        end

        // Async clear mid-ring drops the buzzer before the next edge, then re-rings
        drive(tm(1, 7, 30), 7'b0000010, 1, 0, 0);
        cyc();
        chk("ring_before_clr", 32'(AL_State), 1);
        Clr_AC = 1'b1;
        #1;
        chk("clr_async_buzz", 32'(Buzz), 0);
        chk("clr_async_state", 32'(AL_State), 0);
        model_reset();
        @(posedge Clk); #1;
        Clr_AC = 1'b0;
        cyc();
        chk("rering_after_clr", 32'(AL_State), 1);

        // Ring timeout while minute toggles between :31 and :30
        for (int k = 1; k <= RING_TIMEOUT; k++) begin
            drive(tm(1, 7, (k % 2 == 1) ? 31 : 30), 7'b0000010, 1, 0, 0);
            cyc();
        end
        chk("timeout_done", 32'(AL_State), 3);
        chk("timeout_buzz", 32'(Buzz), 0);
        repeat (2) cyc();
        chk("done_holds", 32'(AL_State), 3);
        drive(tm(1, 7, 31), 7'b0000010, 1, 0, 0);
        cyc();
        chk("done_to_idle", 32'(AL_State), 0);

        // Snooze budget: three full snoozes, the fourth is ignored
        drive(tm(1, 7, 30), 7'b0000010, 1, 0, 0);
        cyc();
        ones = 0;
        for (int s = 0; s < MAX_SNOOZE; s++) begin
            Snooze = 1'b1; cyc(); Snooze = 1'b0;
            chk("snooze_enter", 32'(AL_State), 2);
            for (int t = 0; t < SNOOZE_MIN; t++) begin
                ones ^= 1;
                CTI = tm(1, 7, 30 + ones);
                cyc();
            end
            chk("snooze_expire", 32'(AL_State), 1);
        end
        Snooze = 1'b1; cyc(); Snooze = 1'b0;
        chk("snooze_exhausted_state", 32'(AL_State), 1);
        chk("snooze_exhausted_buzz", 32'(Buzz), 1);
        Stop = 1'b1; cyc(); Stop = 1'b0;
        chk("stop_done", 32'(AL_State), 3);

        // EN_AL drop while snoozing
        drive(tm(1, 7, 32), 7'b0000010, 1, 0, 0); cyc();
        drive(tm(1, 7, 30), 7'b0000010, 1, 0, 0); cyc();
        Snooze = 1'b1; cyc(); Snooze = 1'b0;
        chk("snooze_budget_renewed", 32'(AL_State), 2);
        EN_AL = 1'b0; cyc();
        chk("en_drop_idle", 32'(AL_State), 0);

        // Random stimulus near the alarm time
        for (int n = 0; n < 4000; n++) begin
            logic [14:0] c;
            c = tm(int'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0) ? 8 : 7,
                   30 + int'($urandom_range(0, 2)));
            if (n % 300 == 0) DAY_MASK = 7'($urandom);
            CTI    = c;
            EN_AL  = ($urandom_range(0, 59) != 0);
            Snooze = ($urandom_range(0, 7) == 0);
            Stop   = ($urandom_range(0, 29) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
